// File: rtl/flyhigh_pkg.sv
// ============================================================================
// Module : flyhigh_pkg
// Brief  : Shared types and display constants for the flyhigh game blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package flyhigh_pkg;
    localparam int COORD_W  = 12;
    localparam int D_WIDTH  = 640;
    localparam int D_HEIGHT = 480;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        EXPLODING = 2'd1,
        RESPAWN   = 2'd2
    } enemy_state_t;
endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ============================================================================
// Module : frame_timer
// Brief  : 8-bit loadable frame down-counter; done when the count is zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_timer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_tick,
    output logic       o_done
);
    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_done = (r_count == 8'd0);
endmodule

`default_nettype wire

// File: rtl/enemy_target.sv
// ============================================================================
// Module : enemy_target
// Brief  : Patrolling enemy sprite with bullet hit detection, explosion and
//          respawn intervals, and a saturating hit score.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module enemy_target
    import flyhigh_pkg::*;
#(
    parameter int H_SIZE         = 20,
    parameter int IX             = 320,
    parameter int IY             = 60,
    parameter int D_WIDTH        = flyhigh_pkg::D_WIDTH,
    parameter int D_HEIGHT       = flyhigh_pkg::D_HEIGHT,
    parameter int SPEED          = 1,
    parameter int EXPLODE_FRAMES = 30,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ani_stb,
    input  logic                i_animate,
    input  logic                i_firing,
    input  logic [COORD_W-1:0]  i_bx1,
    input  logic [COORD_W-1:0]  i_bx2,
    input  logic [COORD_W-1:0]  i_by1,
    input  logic [COORD_W-1:0]  i_by2,
    output logic [COORD_W-1:0]  o_x1,
    output logic [COORD_W-1:0]  o_x2,
    output logic [COORD_W-1:0]  o_y1,
    output logic [COORD_W-1:0]  o_y2,
    output logic                o_visible,
    output logic                o_exploding,
    output logic                o_hit,
    output logic [7:0]          o_score
);
    localparam logic [COORD_W-1:0] c_HS     = COORD_W'(H_SIZE);
    localparam logic [COORD_W-1:0] c_SPEED  = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] c_X_INIT = COORD_W'(IX);
    localparam logic [COORD_W-1:0] c_X_MIN  = COORD_W'(H_SIZE);
    localparam logic [COORD_W-1:0] c_X_MAX  = COORD_W'(D_WIDTH - 1 - H_SIZE);
    // Keep the sprite fully on screen vertically even if IY is set too low.
    localparam logic [COORD_W-1:0] c_Y =
        COORD_W'((IY + H_SIZE > D_HEIGHT - 1) ? (D_HEIGHT - 1 - H_SIZE) : IY);
    localparam logic [7:0] c_EXP_LOAD = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0] c_RSP_LOAD = 8'(RESPAWN_FRAMES - 1);

    enemy_state_t       r_state, w_state_nxt;
    logic [COORD_W-1:0] r_x, w_x_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_hit, w_hit_nxt;
    logic [7:0]         r_score, w_score_nxt;
    logic               w_load;
    logic [7:0]         w_load_val;
    logic               w_done;
    logic               w_tick;
    logic               w_overlap;

    assign w_tick = i_ani_stb & i_animate & ~i_rst;

    assign o_x1 = r_x - c_HS;
    assign o_x2 = r_x + c_HS;
    assign o_y1 = c_Y - c_HS;
    assign o_y2 = c_Y + c_HS;

    assign w_overlap = i_firing & (i_bx1 <= o_x2) & (i_bx2 >= o_x1) &
                       (i_by1 <= o_y2) & (i_by2 >= o_y1);

    frame_timer u_frame_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_tick     (w_tick),
        .o_done     (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ALIVE;
            r_x     <= c_X_INIT;
            r_dir   <= 1'b1;
            r_hit   <= 1'b0;
            r_score <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_dir   <= w_dir_nxt;
            r_hit   <= w_hit_nxt;
            r_score <= w_score_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_dir_nxt   = r_dir;
        w_hit_nxt   = 1'b0;
        w_score_nxt = r_score;
        w_load      = 1'b0;
        w_load_val  = c_EXP_LOAD;
        if (w_tick) begin
            case (r_state)
                ALIVE: begin
                    if (w_overlap) begin
                        w_state_nxt = EXPLODING;
                        w_load      = 1'b1;
                        w_load_val  = c_EXP_LOAD;
                        w_hit_nxt   = 1'b1;
                        w_score_nxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                    end else if (r_dir) begin
                        // Widened by one bit so the wall test cannot wrap.
                        if (({1'b0, r_x} + {1'b0, c_SPEED}) > {1'b0, c_X_MAX}) begin
                            w_x_nxt   = c_X_MAX;
                            w_dir_nxt = 1'b0;
                        end else begin
                            w_x_nxt = r_x + c_SPEED;
                        end
                    end else begin
                        if (r_x < (c_X_MIN + c_SPEED)) begin
                            w_x_nxt   = c_X_MIN;
                            w_dir_nxt = 1'b1;
                        end else begin
                            w_x_nxt = r_x - c_SPEED;
                        end
                    end
                end
                EXPLODING: begin
                    if (w_done) begin
                        w_state_nxt = RESPAWN;
                        w_load      = 1'b1;
                        w_load_val  = c_RSP_LOAD;
                    end
                end
                RESPAWN: begin
                    if (w_done) begin
                        w_state_nxt = ALIVE;
                        w_x_nxt     = c_X_INIT;
                        w_dir_nxt   = 1'b1;
                    end
                end
                default: w_state_nxt = ALIVE;
            endcase
        end
    end

    assign o_visible   = (r_state == ALIVE);
    assign o_exploding = (r_state == EXPLODING);
    assign o_hit       = r_hit;
    assign o_score     = r_score;
endmodule

`default_nettype wire
